// File: rtl/pad_word_bridge_pkg.sv
// Shared types and sizing helpers for the pad-to-word bridge.
// The optional core-wait timeout is enabled by defining BRIDGE_TIMEOUT_EN.
package pad_word_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    CORE_WR,
    CORE_RD,
    RESP
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic int laneCount(input int busW, input int padW);
    return busW / padW;
  endfunction

  // A single-lane bridge still needs a one-bit lane field to keep port widths legal.
  function automatic int laneWidth(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/pad_lane_mux.sv
// Combinational selection of one pad-width lane out of a core-width word.
module pad_lane_mux #(
  parameter int PAD_W  = 8,
  parameter int BUS_W  = 32,
  parameter int LANE_W = 2
) (
  input  logic [BUS_W-1:0]  word_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [PAD_W-1:0]  lane_o
);

  assign lane_o = word_i[lane_i*PAD_W +: PAD_W];

endmodule

// File: rtl/pad_word_bridge.sv
// Narrow pad bus to wide core bus bridge: staged lane writes, captured word reads.
// Define BRIDGE_TIMEOUT_EN to bound the core wait and raise the sticky err flag.
module pad_word_bridge
  import pad_word_bridge_pkg::*;
#(
  parameter int PAD_W   = 8,
  parameter int BUS_W   = 32,
  parameter int CADDR_W = 7,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int LANES   = laneCount(BUS_W, PAD_W),
  localparam int LANE_W  = laneWidth(LANES),
  localparam int PADDR_W = CADDR_W + LANE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pad_valid,
  input  logic               pad_wen,
  input  logic [PADDR_W-1:0] pad_addr,
  input  logic [PAD_W-1:0]   pad_wdata,
  output logic [PAD_W-1:0]   pad_rdata,
  output logic               pad_ready,
  output logic               core_valid,
  output logic               core_wen,
  output logic [CADDR_W-1:0] core_addr,
  output logic [BUS_W-1:0]   core_wdata,
  input  logic [BUS_W-1:0]   core_rdata,
  input  logic               core_ready,
  output logic               err
);

  state_e             state_q;
  logic [BUS_W-1:0]   stage_q;
  logic [BUS_W-1:0]   cap_q;
  logic [CADDR_W-1:0] capAddr_q;
  logic               capValid_q;
  logic [CADDR_W-1:0] coreAddr_q;
  logic [LANE_W-1:0]  rdLane_q;
  logic [PAD_W-1:0]   padRdata_q;
  logic               padReady_q;
  logic               coreValid_q;
  logic               coreWen_q;

  logic [CADDR_W-1:0] reqWord;
  logic [LANE_W-1:0]  reqLane;
  logic               reqLastLane;
  logic               capHit;
  logic               commitHitsCap;
  logic               timeoutHit;
  logic [PAD_W-1:0]   capByte;
  logic [PAD_W-1:0]   coreByte;

  assign reqWord       = pad_addr[PADDR_W-1:LANE_W];
  assign reqLane       = pad_addr[LANE_W-1:0];
  assign reqLastLane   = (reqLane == LANE_W'(LANES - 1));
  // Lane 0 always refetches so a fresh word read can observe core-side changes.
  assign capHit        = capValid_q && (reqLane != '0) && (reqWord == capAddr_q);
  assign commitHitsCap = (coreAddr_q == capAddr_q);

  pad_lane_mux #(
    .PAD_W (PAD_W),
    .BUS_W (BUS_W),
    .LANE_W(LANE_W)
  ) u_capMux (
    .word_i(cap_q),
    .lane_i(reqLane),
    .lane_o(capByte)
  );

  pad_lane_mux #(
    .PAD_W (PAD_W),
    .BUS_W (BUS_W),
    .LANE_W(LANE_W)
  ) u_coreMux (
    .word_i(core_rdata),
    .lane_i(rdLane_q),
    .lane_o(coreByte)
  );

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] waitCnt_q;
  logic             err_q;

  assign timeoutHit = (waitCnt_q == CNT_W'(TIMEOUT - 1));
  assign err        = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt_q <= '0;
      err_q     <= 1'b0;
    end else if (state_q == CORE_WR || state_q == CORE_RD) begin
      if (core_ready) begin
        waitCnt_q <= '0;
      end else if (timeoutHit) begin
        waitCnt_q <= '0;
        err_q     <= 1'b1;
      end else begin
        waitCnt_q <= waitCnt_q + CNT_W'(1);
      end
    end else begin
      waitCnt_q <= '0;
    end
  end
`else
  logic [31:0] unusedTimeout;

  assign unusedTimeout = TIMEOUT;
  assign timeoutHit    = 1'b0;
  assign err           = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      cap_q       <= '0;
      capAddr_q   <= '0;
      capValid_q  <= 1'b0;
      coreAddr_q  <= '0;
      rdLane_q    <= '0;
      padRdata_q  <= '0;
      padReady_q  <= 1'b0;
      coreValid_q <= 1'b0;
      coreWen_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pad_valid) begin
            if (pad_wen) begin
              stage_q[reqLane*PAD_W +: PAD_W] <= pad_wdata;
              if (reqLastLane) begin
                coreAddr_q  <= reqWord;
                coreValid_q <= 1'b1;
                coreWen_q   <= 1'b1;
                state_q     <= CORE_WR;
              end else begin
                padReady_q <= 1'b1;
                state_q    <= ACK;
              end
            end else if (capHit) begin
              padRdata_q <= capByte;
              padReady_q <= 1'b1;
              state_q    <= ACK;
            end else begin
              coreAddr_q  <= reqWord;
              rdLane_q    <= reqLane;
              coreValid_q <= 1'b1;
              state_q     <= CORE_RD;
            end
          end
        end
        ACK, RESP: begin
          padReady_q <= 1'b0;
          state_q    <= IDLE;
        end
        CORE_WR: begin
          if (core_ready || timeoutHit) begin
            coreValid_q <= 1'b0;
            coreWen_q   <= 1'b0;
            padReady_q  <= 1'b1;
            state_q     <= RESP;
            if (commitHitsCap) begin
              capValid_q <= 1'b0;
            end
          end
        end
        CORE_RD: begin
          if (core_ready) begin
            cap_q       <= core_rdata;
            capAddr_q   <= coreAddr_q;
            capValid_q  <= 1'b1;
            padRdata_q  <= coreByte;
            coreValid_q <= 1'b0;
            padReady_q  <= 1'b1;
            state_q     <= RESP;
          end else if (timeoutHit) begin
            padRdata_q  <= '1;
            coreValid_q <= 1'b0;
            padReady_q  <= 1'b1;
            state_q     <= RESP;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pad_rdata  = padRdata_q;
  assign pad_ready  = padReady_q;
  assign core_valid = coreValid_q;
  assign core_wen   = coreWen_q;
  assign core_addr  = coreAddr_q;
  assign core_wdata = stage_q;

endmodule
